// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the IF/ID/RR/EX/MEM/WB pipeline.
// Tracks the instructions in RR and EX in a small shadow pipeline and produces
// the PC/IF-ID hold, the ID->RR bubble kill, the ID_RR stall and the IF/ID flush.
// Covers load-use stalls, jump squash and multi-cycle memory freeze.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALLS = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [25:0]      instr_id,
    input  logic             valid_id,
    input  logic             RegWriteD,
    input  logic             MemReadD,
    input  logic             MemWriteD,
    input  logic             RegDstD,
    input  logic             JumpD,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             kill_id,
    output logic             stall_idrr,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] hazard_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } state_t;

    state_t           state;
    state_t           savedState;
    state_t           effState;
    logic [1:0]       cnt;
    logic [CNT_W-1:0] hazardCnt;

    logic             rrV, rrLoad, exV, exLoad;
    logic [4:0]       rrDest, exDest;

    logic [4:0]       rs, rt, rd, destId;
    logic             rtUsed, writerId, hz;
    logic             stallPc, stallIfid, killId, stallIdrr, flushIfid, countInc;
    logic             unusedBits;

    assign rs       = instr_id[25:21];
    assign rt       = instr_id[20:16];
    assign rd       = instr_id[15:11];
    assign destId   = RegDstD ? rd : rt;
    assign writerId = valid_id & RegWriteD & (destId != 5'd0);
    assign rtUsed   = RegDstD | MemWriteD;
    assign hz       = rrV & rrLoad & valid_id &
                      ((rrDest == rs) | (rtUsed & (rrDest == rt)));

    // The EX entry and the immediate field are carried for completeness only.
    assign unusedBits = ^{exV, exLoad, exDest, instr_id[10:0]};

    // On the release cycle of a freeze the controller already behaves as the saved state.
    assign effState = (state == FREEZE && !mem_busy) ? savedState : state;

    // Combinational stall/kill/flush decisions from state, shadow RR entry and ID inputs.
    always_comb begin
        stallPc   = 1'b0;
        stallIfid = 1'b0;
        killId    = 1'b0;
        stallIdrr = 1'b0;
        flushIfid = 1'b0;
        countInc  = 1'b0;
        if (mem_busy) begin
            stallPc   = 1'b1;
            stallIfid = 1'b1;
            stallIdrr = 1'b1;
        end else begin
            case (effState)
                RUN: begin
                    if (hz) begin
                        stallPc   = 1'b1;
                        stallIfid = 1'b1;
                        killId    = 1'b1;
                        countInc  = 1'b1;
                    end else if (valid_id && JumpD) begin
                        flushIfid = 1'b1;
                    end
                end
                LU_STALL: begin
                    stallPc   = 1'b1;
                    stallIfid = 1'b1;
                    killId    = 1'b1;
                    countInc  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State machine, stall down-counter, shadow pipeline and hazard counter.
    // Shadow advances only when ID_RR actually advances (no mem_busy), so it mirrors the real RR/EX contents.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= RUN;
            savedState <= RUN;
            cnt        <= '0;
            hazardCnt  <= '0;
            rrV        <= 1'b0;
            rrLoad     <= 1'b0;
            rrDest     <= '0;
            exV        <= 1'b0;
            exLoad     <= 1'b0;
            exDest     <= '0;
        end else if (mem_busy) begin
            if (state != FREEZE) begin
                savedState <= state;
                state      <= FREEZE;
            end
        end else begin
            exV    <= rrV;
            exLoad <= rrLoad;
            exDest <= rrDest;
            if (killId) begin
                rrV    <= 1'b0;
                rrLoad <= 1'b0;
                rrDest <= '0;
            end else begin
                rrV    <= writerId;
                rrLoad <= MemReadD;
                rrDest <= destId;
            end
            if (countInc && hazardCnt != '1)
                hazardCnt <= hazardCnt + CNT_W'(1);
            case (effState)
                LU_STALL: begin
                    cnt   <= cnt - 2'd1;
                    state <= (cnt <= 2'd1) ? RUN : LU_STALL;
                end
                default: begin
                    if (hz && LOAD_USE_STALLS > 1) begin
                        cnt   <= 2'(LOAD_USE_STALLS - 1);
                        state <= LU_STALL;
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    assign stall_pc     = reset & stallPc;
    assign stall_ifid   = reset & stallIfid;
    assign kill_id      = reset & killId;
    assign stall_idrr   = reset & stallIdrr;
    assign flush_ifid   = reset & flushIfid;
    assign hazard_count = reset ? hazardCnt : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: three instances share the ID inputs
// (1-stall, 3-stall, and 3-stall with a 2-bit counter for saturation).
module tb_pipe_hazard_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [25:0] instr_id;
    logic        valid_id, RegWriteD, MemReadD, MemWriteD, RegDstD, JumpD, mem_busy;

    logic        sp1, si1, k1, sr1, f1;
    logic        sp3, si3, k3, sr3, f3;
    logic        spS, siS, kS, srS, fS;
    logic [15:0] hc1, hc3;
    logic [1:0]  hcS;
    logic [4:0]  o1, o3, oS;

    // output order in vectors: {stall_pc, stall_ifid, kill_id, stall_idrr, flush_ifid}
    assign o1 = {sp1, si1, k1, sr1, f1};
    assign o3 = {sp3, si3, k3, sr3, f3};
    assign oS = {spS, siS, kS, srS, fS};

    pipe_hazard_ctrl #(.LOAD_USE_STALLS(1), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .instr_id(instr_id), .valid_id(valid_id),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MemWriteD(MemWriteD),
        .RegDstD(RegDstD), .JumpD(JumpD), .mem_busy(mem_busy),
        .stall_pc(sp1), .stall_ifid(si1), .kill_id(k1), .stall_idrr(sr1),
        .flush_ifid(f1), .hazard_count(hc1));

    pipe_hazard_ctrl #(.LOAD_USE_STALLS(3), .CNT_W(16)) dut3 (
        .clock(clock), .reset(reset), .instr_id(instr_id), .valid_id(valid_id),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MemWriteD(MemWriteD),
        .RegDstD(RegDstD), .JumpD(JumpD), .mem_busy(mem_busy),
        .stall_pc(sp3), .stall_ifid(si3), .kill_id(k3), .stall_idrr(sr3),
        .flush_ifid(f3), .hazard_count(hc3));

    pipe_hazard_ctrl #(.LOAD_USE_STALLS(3), .CNT_W(2)) dutS (
        .clock(clock), .reset(reset), .instr_id(instr_id), .valid_id(valid_id),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MemWriteD(MemWriteD),
        .RegDstD(RegDstD), .JumpD(JumpD), .mem_busy(mem_busy),
        .stall_pc(spS), .stall_ifid(siS), .kill_id(kS), .stall_idrr(srS),
        .flush_ifid(fS), .hazard_count(hcS));

    typedef struct packed {
        logic [25:0] instr;
        logic v, rw, mr, mw, rd, j, busy;
    } stim_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [4:0]  expQ[$];

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t lw(input logic [4:0] rt, input logic [4:0] rs);
        stim_t s;
        s = '0;
        s.instr = {rs, rt, 16'h0000};
        s.v = 1'b1; s.rw = 1'b1; s.mr = 1'b1;
        return s;
    endfunction

    function automatic stim_t sw(input logic [4:0] rt, input logic [4:0] rs);
        stim_t s;
        s = '0;
        s.instr = {rs, rt, 16'h0000};
        s.v = 1'b1; s.mw = 1'b1;
        return s;
    endfunction

    function automatic stim_t addi(input logic [4:0] rt, input logic [4:0] rs);
        stim_t s;
        s = '0;
        s.instr = {rs, rt, 16'h0004};
        s.v = 1'b1; s.rw = 1'b1;
        return s;
    endfunction

    function automatic stim_t add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        stim_t s;
        s = '0;
        s.instr = {rs, rt, rd, 11'h020};
        s.v = 1'b1; s.rw = 1'b1; s.rd = 1'b1;
        return s;
    endfunction

    function automatic stim_t jr(input logic [4:0] rs);
        stim_t s;
        s = '0;
        s.instr = {rs, 21'h0};
        s.v = 1'b1; s.j = 1'b1;
        return s;
    endfunction

    function automatic stim_t busy(input stim_t s);
        stim_t b;
        b = s;
        b.busy = 1'b1;
        return b;
    endfunction

    task automatic apply(input stim_t s);
        instr_id  = s.instr;
        valid_id  = s.v;
        RegWriteD = s.rw;
        MemReadD  = s.mr;
        MemWriteD = s.mw;
        RegDstD   = s.rd;
        JumpD     = s.j;
        mem_busy  = s.busy;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        apply(nop());
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(busy(jr(5'd1)));
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (o1 !== 5'b0 || o3 !== 5'b0 || oS !== 5'b0) begin
                errors++;
                $display("FAIL reset_outs[%0d]: got %b/%b/%b want 00000", i, o1, o3, oS);
            end
            checks++;
            if (hc1 !== 16'd0 || hc3 !== 16'd0 || hcS !== 2'd0) begin
                errors++;
                $display("FAIL reset_count[%0d]: got %0d/%0d/%0d want 0", i, hc1, hc3, hcS);
            end
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        apply(nop());
        @(negedge clock);
        checks++;
        if (o1 !== 5'b0 || o3 !== 5'b0 || oS !== 5'b0 || hc3 !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b/%b/%b cnt %0d want 00000 cnt 0", o1, o3, oS, hc3);
        end
        @(posedge clock);
        #1;
    endtask

    // dut1: lw r5; lw r6,0(r5) stalls 1 cycle; add r8,r6,r1 stalls only once the second load is in RR.
    task automatic test_lu1();
        stim_t      sq[0:4];
        logic [4:0] eq[0:4];
        logic [4:0] exp;
        do_reset();
        sq = '{lw(5'd5, 5'd1), lw(5'd6, 5'd5), lw(5'd6, 5'd5), add(5'd8, 5'd6, 5'd1), add(5'd8, 5'd6, 5'd1)};
        eq = '{5'b00000, 5'b11100, 5'b00000, 5'b11100, 5'b00000};
        for (int i = 0; i < 5; i++) begin
            apply(sq[i]);
            expQ.push_back(eq[i]);
            @(negedge clock);
            exp = expQ.pop_front();
            checks++;
            if (o1 !== exp) begin
                errors++;
                $display("FAIL lu1[%0d]: got %b want %b", i, o1, exp);
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (hc1 !== 16'd2) begin
            errors++;
            $display("FAIL lu1_count: got %0d want 2", hc1);
        end
    endtask

    // dut3: 3-cycle stall, then load to r0 never stalls.
    task automatic test_lu3();
        stim_t      sq[0:7];
        logic [4:0] eq[0:7];
        logic [4:0] exp;
        do_reset();
        sq = '{lw(5'd5, 5'd1), add(5'd6, 5'd5, 5'd7), add(5'd6, 5'd5, 5'd7), add(5'd6, 5'd5, 5'd7),
               add(5'd6, 5'd5, 5'd7), nop(), lw(5'd0, 5'd1), add(5'd6, 5'd0, 5'd0)};
        eq = '{5'b00000, 5'b11100, 5'b11100, 5'b11100, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        for (int i = 0; i < 8; i++) begin
            apply(sq[i]);
            expQ.push_back(eq[i]);
            @(negedge clock);
            exp = expQ.pop_front();
            checks++;
            if (o3 !== exp) begin
                errors++;
                $display("FAIL lu3[%0d]: got %b want %b", i, o3, exp);
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (hc3 !== 16'd3 || hcS !== 2'd3) begin
            errors++;
            $display("FAIL lu3_count: got %0d/%0d want 3/3", hc3, hcS);
        end
    endtask

    // dut3: load already in EX, addi rt not a source, store rt is a source.
    task automatic test_independent();
        stim_t      sq[0:9];
        logic [4:0] eq[0:9];
        logic [4:0] exp;
        sq = '{lw(5'd5, 5'd1), add(5'd9, 5'd1, 5'd2), add(5'd6, 5'd5, 5'd7), lw(5'd5, 5'd1),
               addi(5'd5, 5'd1), lw(5'd5, 5'd1), sw(5'd5, 5'd1), sw(5'd5, 5'd1), sw(5'd5, 5'd1),
               sw(5'd5, 5'd1)};
        eq = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
               5'b11100, 5'b11100, 5'b11100, 5'b00000};
        for (int i = 0; i < 10; i++) begin
            apply(sq[i]);
            expQ.push_back(eq[i]);
            @(negedge clock);
            exp = expQ.pop_front();
            checks++;
            if (o3 !== exp) begin
                errors++;
                $display("FAIL indep[%0d]: got %b want %b", i, o3, exp);
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (hc3 !== 16'd6 || hcS !== 2'd3) begin
            errors++;
            $display("FAIL indep_count: got %0d/%0d want 6/3 (saturated)", hc3, hcS);
        end
    endtask

    // dut3: mem_busy for 4 cycles in the 2nd cycle of a 3-cycle stall.
    task automatic test_freeze_in_stall();
        stim_t      sq[0:8];
        logic [4:0] eq[0:8];
        logic [4:0] exp;
        stim_t      a;
        do_reset();
        a  = add(5'd6, 5'd5, 5'd7);
        sq = '{lw(5'd5, 5'd1), a, busy(a), busy(a), busy(a), busy(a), a, a, a};
        eq = '{5'b00000, 5'b11100, 5'b11010, 5'b11010, 5'b11010, 5'b11010,
               5'b11100, 5'b11100, 5'b00000};
        for (int i = 0; i < 9; i++) begin
            apply(sq[i]);
            expQ.push_back(eq[i]);
            @(negedge clock);
            exp = expQ.pop_front();
            checks++;
            if (o3 !== exp) begin
                errors++;
                $display("FAIL freeze[%0d]: got %b want %b", i, o3, exp);
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (hc3 !== 16'd3) begin
            errors++;
            $display("FAIL freeze_count: got %0d want 3", hc3);
        end
    endtask

    // dut3: jump held behind a stall, plain jump, jump under mem_busy.
    task automatic test_jump();
        stim_t      sq[0:10];
        logic [4:0] eq[0:10];
        logic [4:0] exp;
        do_reset();
        sq = '{lw(5'd5, 5'd1), jr(5'd5), jr(5'd5), jr(5'd5), jr(5'd5), nop(),
               jr(5'd1), nop(), busy(jr(5'd1)), jr(5'd1), nop()};
        eq = '{5'b00000, 5'b11100, 5'b11100, 5'b11100, 5'b00001, 5'b00000,
               5'b00001, 5'b00000, 5'b11010, 5'b00001, 5'b00000};
        for (int i = 0; i < 11; i++) begin
            apply(sq[i]);
            expQ.push_back(eq[i]);
            @(negedge clock);
            exp = expQ.pop_front();
            checks++;
            if (o3 !== exp) begin
                errors++;
                $display("FAIL jump[%0d]: got %b want %b", i, o3, exp);
            end
            @(posedge clock);
            #1;
        end
    endtask

    // dut3: reset in the middle of a stall abandons it and clears the shadow.
    task automatic test_reset_mid_stall();
        do_reset();
        apply(lw(5'd5, 5'd1));
        @(posedge clock);
        #1;
        apply(add(5'd6, 5'd5, 5'd7));
        @(negedge clock);
        checks++;
        if (o3 !== 5'b11100) begin
            errors++;
            $display("FAIL midrst_pre: got %b want 11100", o3);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (o3 !== 5'b00000 || hc3 !== 16'd0) begin
            errors++;
            $display("FAIL midrst_low: got %b cnt %0d want 00000 cnt 0", o3, hc3);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (o3 !== 5'b00000 || hc3 !== 16'd0) begin
            errors++;
            $display("FAIL midrst_after: got %b cnt %0d want 00000 cnt 0", o3, hc3);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        apply(nop());
        @(posedge clock);
        #1;
        test_reset();
        test_lu1();
        test_lu3();
        test_independent();
        test_freeze_in_stall();
        test_jump();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
